// File: rtl/mmt_pkg.sv
// Shared types and constants for the MMT matrix-engine control front end.
// Holds the FSM states, operand/mode encodings and small index helpers.
package mmt_pkg;

    localparam int NUM_MAT = 32;
    localparam int NUM_CMD = 10;
    localparam int AW      = 13;
    localparam int CW      = 14;  // beat counter must reach NUM_MAT*256

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_CMD,
        ST_CMD,
        ST_FETCH,
        ST_WAIT_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_A = 2'd0,
        OP_B = 2'd1,
        OP_C = 2'd2
    } op_e;

    typedef enum logic [1:0] {
        MODE_ABC = 2'd0,
        MODE_AT  = 2'd1,
        MODE_BT  = 2'd2,
        MODE_CT  = 2'd3
    } mode_e;

    // Largest row/column index for a given size code (N-1, N = 2 << size).
    function automatic logic [3:0] last_rc(input logic [1:0] size);
        return 4'((5'd2 << size) - 5'd1);
    endfunction

    function automatic logic is_transposed(input op_e op, input mode_e md);
        return (op == OP_A && md == MODE_AT) ||
               (op == OP_B && md == MODE_BT) ||
               (op == OP_C && md == MODE_CT);
    endfunction

endpackage

// File: rtl/mmt_addr_gen.sv
// Operand SRAM address: matrix base plus row-major or transposed element offset.
// Purely combinational; N and E are powers of two so everything reduces to shifts.
module mmt_addr_gen
    import mmt_pkg::*;
(
    input  logic [4:0]    idx_i,
    input  logic [1:0]    size_i,
    input  logic          transpose_i,
    input  logic [3:0]    row_i,
    input  logic [3:0]    col_i,
    output logic [AW-1:0] addr_o
);

    logic [3:0] sh_base;
    logic [2:0] sh_major;
    logic [3:0] major;
    logic [3:0] minor;

    always_comb begin
        sh_base  = {size_i, 1'b0} + 4'd2;
        sh_major = {1'b0, size_i} + 3'd1;
        major    = transpose_i ? col_i : row_i;
        minor    = transpose_i ? row_i : col_i;
        addr_o   = (AW'(idx_i) << sh_base) + (AW'(major) << sh_major) + AW'(minor);
    end

endmodule

// File: rtl/mmt_op_scheduler.sv
// MMT control front end: stores the streamed matrices into operand SRAM, then for each
// 3-beat command streams operands A, B, C to the datapath and waits for its done pulse.
module mmt_op_scheduler
    import mmt_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [7:0]    matrix,
    input  logic [1:0]    matrix_size,
    input  logic          in_valid2,
    input  logic [4:0]    matrix_idx,
    input  logic [1:0]    mode,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [7:0]    sram_wdata,
    input  logic          dp_ready,
    output logic          op_valid,
    output logic [1:0]    op_sel,
    output logic          op_last,
    output logic [1:0]    dim,
    input  logic          dp_done,
    output logic          busy
);

    state_e        state_q;
    logic [1:0]    dim_q;
    mode_e         mode_q;
    logic [4:0]    idx_a_q, idx_b_q, idx_c_q;
    logic          cmd_beat_q;
    logic [CW-1:0] wr_cnt_q;
    logic [3:0]    cmd_cnt_q;
    op_e           op_q;
    logic [3:0]    r_q, c_q;
    logic          sram_we_q, op_valid_q, op_last_q, busy_q;
    logic [AW-1:0] sram_addr_q;
    logic [7:0]    sram_wdata_q;
    logic [1:0]    op_sel_q;

    op_e           op_d, gen_op;
    logic [3:0]    r_d, c_d, gen_r, gen_c, nm1;
    logic [4:0]    gen_idx;
    logic          elem_last;
    logic [3:0]    wr_shift;
    logic [CW-1:0] wr_total;
    logic [AW-1:0] gen_addr;

    // Next element in logical row-major order; rolls A -> B -> C with no gap.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        op_d      = op_q;
        r_d       = r_q;
        c_d       = c_q;
        nm1       = last_rc(dim_q);
        elem_last = (r_q == nm1) && (c_q == nm1);
        wr_shift  = {dim_q, 1'b0} + 4'd2;
        wr_total  = CW'(NUM_MAT) << wr_shift;
        if (c_q == nm1) begin
            c_d = '0;
            if (r_q == nm1) begin
                r_d = '0;
                if (op_q == OP_A) op_d = OP_B;
                else              op_d = OP_C;
            end else begin
                r_d = r_q + 4'd1;
            end
        end else begin
            c_d = c_q + 4'd1;
        end

        gen_op = OP_A;
        gen_r  = '0;
        gen_c  = '0;
        if (state_q == ST_FETCH) begin
            gen_op = op_d;
            gen_r  = r_d;
            gen_c  = c_d;
        end
        case (gen_op)
            OP_B:    gen_idx = idx_b_q;
            OP_C:    gen_idx = idx_c_q;
            default: gen_idx = idx_a_q;
        endcase
    end

    mmt_addr_gen u_addr_gen (
        .idx_i       (gen_idx),
        .size_i      (dim_q),
        .transpose_i (is_transposed(gen_op, mode_q)),
        .row_i       (gen_r),
        .col_i       (gen_c),
        .addr_o      (gen_addr)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: no storage array lives here, so every register, outputs included, is reset.
            state_q      <= ST_IDLE;
            dim_q        <= '0;
            mode_q       <= MODE_ABC;
            idx_a_q      <= '0;
            idx_b_q      <= '0;
            idx_c_q      <= '0;
            cmd_beat_q   <= 1'b0;
            wr_cnt_q     <= '0;
            cmd_cnt_q    <= '0;
            op_q         <= OP_A;
            r_q          <= '0;
            c_q          <= '0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            op_valid_q   <= 1'b0;
            op_sel_q     <= '0;
            op_last_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sram_we_q  <= 1'b0;
            op_valid_q <= 1'b0;
            op_last_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_q      <= ST_LOAD;
                        busy_q       <= 1'b1;
                        dim_q        <= matrix_size;
                        sram_we_q    <= 1'b1;
                        sram_addr_q  <= '0;
                        sram_wdata_q <= matrix;
                        wr_cnt_q     <= CW'(1);
                    end
                end
                ST_LOAD: begin
                    if (!in_valid) begin
                        state_q <= ST_WAIT_CMD;
                    end else if (wr_cnt_q < wr_total) begin
                        sram_we_q    <= 1'b1;
                        sram_addr_q  <= AW'(wr_cnt_q);
                        sram_wdata_q <= matrix;
                        wr_cnt_q     <= wr_cnt_q + CW'(1);
                    end
                end
                ST_WAIT_CMD: begin
                    if (in_valid2) begin
                        state_q    <= ST_CMD;
                        idx_a_q    <= matrix_idx;
                        mode_q     <= mode_e'(mode);
                        cmd_beat_q <= 1'b0;
                    end
                end
                ST_CMD: begin
                    if (!cmd_beat_q) begin
                        idx_b_q    <= matrix_idx;
                        cmd_beat_q <= 1'b1;
                    end else begin
                        idx_c_q     <= matrix_idx;
                        state_q     <= ST_FETCH;
                        op_q        <= OP_A;
                        r_q         <= '0;
                        c_q         <= '0;
                        sram_addr_q <= gen_addr;
                    end
                end
                ST_FETCH: begin
                    // sram_addr always holds the pending element; a ready cycle consumes it.
                    if (dp_ready) begin
                        op_valid_q <= 1'b1;
                        op_sel_q   <= op_q;
                        op_last_q  <= elem_last;
                        if (elem_last && op_q == OP_C) begin
                            state_q <= ST_WAIT_DONE;
                        end else begin
                            op_q        <= op_d;
                            r_q         <= r_d;
                            c_q         <= c_d;
                            sram_addr_q <= gen_addr;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (dp_done) begin
                        if (cmd_cnt_q == 4'(NUM_CMD - 1)) begin
                            cmd_cnt_q <= '0;
                            state_q   <= ST_IDLE;
                            busy_q    <= 1'b0;
                        end else begin
                            cmd_cnt_q <= cmd_cnt_q + 4'd1;
                            state_q   <= ST_WAIT_CMD;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign op_valid   = op_valid_q;
    assign op_sel     = op_sel_q;
    assign op_last    = op_last_q;
    assign dim        = dim_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mmt_op_scheduler.sv
// Directed self-checking bench for mmt_op_scheduler: load, fetch order, transpose,
// back-pressure, command counting and asynchronous reset.
module tb_mmt_op_scheduler;
    import mmt_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    matrix = '0;
    logic [1:0]    matrix_size = '0;
    logic          in_valid2 = 1'b0;
    logic [4:0]    matrix_idx = '0;
    logic [1:0]    mode = '0;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_wdata;
    logic          dp_ready = 1'b0;
    logic          op_valid;
    logic [1:0]    op_sel;
    logic          op_last;
    logic [1:0]    dim;
    logic          dp_done = 1'b0;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mmt_op_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .matrix      (matrix),
        .matrix_size (matrix_size),
        .in_valid2   (in_valid2),
        .matrix_idx  (matrix_idx),
        .mode        (mode),
        .sram_we     (sram_we),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .dp_ready    (dp_ready),
        .op_valid    (op_valid),
        .op_sel      (op_sel),
        .op_last     (op_last),
        .dim         (dim),
        .dp_done     (dp_done),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_addr(input int idx, input int sz, input bit t, input int r, input int c);
        int n;
        n = 2 << sz;
        return idx * n * n + (t ? c * n + r : r * n + c);
    endfunction

    // Stream `beats` bytes (value = beat index) and check the registered write port.
    task automatic load(input int sz, input int beats);
        int total;
        total = NUM_MAT * (2 << sz) * (2 << sz);
        @(negedge clk);
        in_valid    = 1'b1;
        matrix_size = 2'(sz);
        matrix      = 8'(0);
        for (int k = 0; k < beats; k++) begin
            @(negedge clk);
            if (k < total) begin
                check("load_we", sram_we, 1);
                check("load_addr", sram_addr, k);
                check("load_wdata", sram_wdata, k % 256);
            end else begin
                check("drop_we", sram_we, 0);
                check("drop_addr", sram_addr, total - 1);
            end
            check("load_busy", busy, 1);
            matrix_size = 2'(~sz);
            if (k + 1 < beats) matrix = 8'(k + 1);
            else               in_valid = 1'b0;
        end
        @(negedge clk);
        check("load_end_we", sram_we, 0);
        check("load_end_busy", busy, 1);
        check("load_dim", dim, sz);
    endtask

    task automatic issue_cmd(input int ia, input int ib, input int ic, input int md);
        @(negedge clk);
        in_valid2  = 1'b1;
        matrix_idx = 5'(ia);
        mode       = 2'(md);
        @(negedge clk);
        matrix_idx = 5'(ib);
        mode       = 2'(~md);
        @(negedge clk);
        matrix_idx = 5'(ic);
    endtask

    // One full command: fetch checking against the model, then the dp_done handshake.
    task automatic run_cmd(input int ia, input int ib, input int ic, input int md, input int sz,
                           input bit toggle, input bit inject, input bit expect_idle);
        int n, e, got, cyc, sel, idx;
        bit prev_rdy;
        logic [AW-1:0] prev_addr;
        n = 2 << sz;
        e = n * n;
        issue_cmd(ia, ib, ic, md);
        @(negedge clk);
        in_valid2  = 1'b0;
        matrix_idx = '0;
        got        = 0;
        cyc        = 0;
        prev_addr  = sram_addr;
        prev_rdy   = 1'b1;
        dp_ready   = 1'b1;
        while (got < 3 * e && cyc < 8 * e + 16) begin
            @(negedge clk);
            cyc++;
            check("op_valid", op_valid, prev_rdy);
            check("fetch_we", sram_we, 0);
            if (op_valid) begin
                sel = got / e;
                idx = (sel == 0) ? ia : (sel == 1) ? ib : ic;
                check("op_sel", op_sel, sel);
                check("op_last", op_last, (got % e) == e - 1);
                check("rd_addr", prev_addr,
                      exp_addr(idx, sz, md == sel + 1, (got % e) / n, got % n));
                got++;
            end
            prev_addr = sram_addr;
            dp_done   = inject && cyc == 3;
            prev_rdy  = (got < 3 * e) && (!toggle || (cyc % 2 == 0));
            dp_ready  = prev_rdy;
        end
        check("fetch_count", got, 3 * e);
        @(negedge clk);
        check("post_valid", op_valid, 0);
        check("post_busy", busy, 1);
        in_valid2  = 1'b1;
        matrix_idx = 5'd31;
        @(negedge clk);
        in_valid2  = 1'b0;
        matrix_idx = '0;
        dp_done    = 1'b1;
        @(negedge clk);
        dp_done = 1'b0;
        check("done_busy", busy, !expect_idle);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_we", sram_we, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_valid", op_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_dim", dim, 0);

        // 2x2 load with two surplus beats that must be dropped.
        load(0, 130);

        // in_valid while waiting for a command is ignored.
        @(negedge clk);
        in_valid = 1'b1;
        matrix   = 8'h55;
        @(negedge clk);
        in_valid = 1'b0;
        check("wait_cmd_we", sram_we, 0);

        // Ten 2x2 commands; fifth has a stray dp_done in FETCH, eighth uses back-pressure.
        for (int i = 0; i < NUM_CMD; i++)
            run_cmd((i * 3) % 32, 31 - i, i, i % 4, 0, i == 7, i == 4, i == NUM_CMD - 1);

        // 4x4 pattern and the directed fetch scenarios.
        load(1, NUM_MAT * 16);
        run_cmd(3, 5, 7, 0, 1, 1'b0, 1'b0, 1'b0);
        run_cmd(2, 9, 9, 1, 1, 1'b0, 1'b0, 1'b0);
        run_cmd(3, 5, 7, 0, 1, 1'b1, 1'b0, 1'b0);
        run_cmd(4, 6, 8, 2, 1, 1'b0, 1'b0, 1'b0);
        run_cmd(1, 1, 30, 3, 1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a fetch.
        issue_cmd(1, 2, 3, 0);
        @(negedge clk);
        in_valid2 = 1'b0;
        dp_ready  = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_we", sram_we, 0);
        check("arst_addr", sram_addr, 0);
        check("arst_wdata", sram_wdata, 0);
        check("arst_valid", op_valid, 0);
        check("arst_sel", op_sel, 0);
        check("arst_last", op_last, 0);
        check("arst_dim", dim, 0);
        check("arst_busy", busy, 0);
        dp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        load(2, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
